// File: rtl/mm_pkg.sv
// Shared types and constants for the matrix-multiply job sequencer.
//   seq_state_t : sequencer FSM states
//   STAT_*      : bit positions inside the packed status word
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } seq_state_t;

  localparam int unsigned STAT_BUSY  = 0;
  localparam int unsigned STAT_DONE  = 1;
  localparam int unsigned STAT_ERR   = 2;
  localparam int unsigned STAT_ABORT = 3;

endpackage

// File: rtl/mm_idx_counter.sv
// Nested (i,j,k) wrap counter, k innermost, then j, then i.
// Ports:
//   clk, rst_n          : clock, async active-low reset
//   load                : reset indices to (0,0,0) using the m/n/k_len presented this cycle
//   step                : advance one position in the loop nest
//   m_len, n_len, k_len : loop bounds (nonzero while stepping)
//   i, j, k             : current indices (registered)
//   first, last         : k==0 / k==k_len-1 for the current indices (registered)
//   is_final            : current position is (m_len-1, n_len-1, k_len-1) (registered)
module mm_idx_counter #(
  parameter int unsigned DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             step,
  input  logic [DIM_W-1:0] m_len,
  input  logic [DIM_W-1:0] n_len,
  input  logic [DIM_W-1:0] k_len,
  output logic [DIM_W-1:0] i,
  output logic [DIM_W-1:0] j,
  output logic [DIM_W-1:0] k,
  output logic             first,
  output logic             last,
  output logic             is_final
);

  logic [DIM_W-1:0] m_max, n_max, k_max;
  logic [DIM_W-1:0] i_d, j_d, k_d;

  assign m_max = m_len - DIM_W'(1);
  assign n_max = n_len - DIM_W'(1);
  assign k_max = k_len - DIM_W'(1);

  // Next indices: load wins over step; wrap inner-to-outer.
  always_comb begin
    i_d = i;
    j_d = j;
    k_d = k;
    if (load) begin
      i_d = '0;
      j_d = '0;
      k_d = '0;
    end else if (step) begin
      if (k == k_max) begin
        k_d = '0;
        if (j == n_max) begin
          j_d = '0;
          i_d = (i == m_max) ? '0 : i + DIM_W'(1);
        end else begin
          j_d = j + DIM_W'(1);
        end
      end else begin
        k_d = k + DIM_W'(1);
      end
    end
  end

  // Flags are computed from the next indices so they stay aligned with them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i        <= '0;
      j        <= '0;
      k        <= '0;
      first    <= 1'b0;
      last     <= 1'b0;
      is_final <= 1'b0;
    end else if (load || step) begin
      i        <= i_d;
      j        <= j_d;
      k        <= k_d;
      first    <= (k_d == '0);
      last     <= (k_d == k_max);
      is_final <= (k_d == k_max) && (j_d == n_max) && (i_d == m_max);
    end
  end

endmodule

// File: rtl/mm_job_sequencer.sv
// Walks the (i,j,k) loop nest of C[MxN] = A[MxK]*B[KxN], issuing one MAC op
// per handshake, counting write-back acks and producing the status bits.
// Ports:
//   clk, rst_n               : clock, async active-low reset
//   start, abort, clr_done   : one-cycle control pulses
//   cfg_m, cfg_k, cfg_n      : job dimensions, latched on an accepted start
//   op_valid/op_ready        : MAC op handshake; op_i/j/k, op_first, op_last payload
//   wb_ack                   : one pulse per C element written back
//   busy                     : job in progress
//   status                   : {28'b0, aborted, err, done, busy}
module mm_job_sequencer
  import mm_pkg::*;
#(
  parameter int unsigned DIM_W  = 16,
  parameter int unsigned STAT_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              clr_done,
  input  logic [DIM_W-1:0]  cfg_m,
  input  logic [DIM_W-1:0]  cfg_k,
  input  logic [DIM_W-1:0]  cfg_n,
  output logic              op_valid,
  input  logic              op_ready,
  output logic [DIM_W-1:0]  op_i,
  output logic [DIM_W-1:0]  op_j,
  output logic [DIM_W-1:0]  op_k,
  output logic              op_first,
  output logic              op_last,
  input  logic              wb_ack,
  output logic              busy,
  output logic [STAT_W-1:0] status
);

  localparam int unsigned CNT_W = 2 * DIM_W;

  seq_state_t       state_q, state_d;
  logic [DIM_W-1:0] m_q, k_q, n_q;
  logic [CNT_W-1:0] wb_cnt_q, wb_cnt_d;
  logic [CNT_W-1:0] mn_total;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             aborted_q, aborted_d;
  logic             cfg_ok, start_go, op_hs, idx_final;
  logic [DIM_W-1:0] lim_m, lim_k, lim_n;

  assign cfg_ok   = (cfg_m != '0) && (cfg_k != '0) && (cfg_n != '0);
  assign start_go = (state_q == IDLE) && start && cfg_ok;
  assign op_valid = (state_q == ISSUE);
  assign busy     = (state_q != IDLE);
  assign op_hs    = op_valid && op_ready;
  assign mn_total = CNT_W'(m_q) * CNT_W'(n_q);

  // The counter loads from the live cfg on the start cycle, the latched copy afterwards.
  assign lim_m = start_go ? cfg_m : m_q;
  assign lim_k = start_go ? cfg_k : k_q;
  assign lim_n = start_go ? cfg_n : n_q;

  mm_idx_counter #(.DIM_W(DIM_W)) u_idx (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start_go),
    .step     (op_hs),
    .m_len    (lim_m),
    .n_len    (lim_n),
    .k_len    (lim_k),
    .i        (op_i),
    .j        (op_j),
    .k        (op_k),
    .first    (op_first),
    .last     (op_last),
    .is_final (idx_final)
  );

  // State and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wb_cnt_q  <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wb_cnt_q  <= wb_cnt_d;
      done_q    <= done_d;
      err_q     <= err_d;
      aborted_q <= aborted_d;
    end
  end

  // Job dimensions are frozen for the lifetime of a job.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_q <= '0;
      k_q <= '0;
      n_q <= '0;
    end else if (start_go) begin
      m_q <= cfg_m;
      k_q <= cfg_k;
      n_q <= cfg_n;
    end
  end

  // Next state; clr_done is applied first so any completion event overrides it.
  always_comb begin
    state_d   = state_q;
    wb_cnt_d  = wb_cnt_q;
    done_d    = done_q;
    err_d     = err_q;
    aborted_d = aborted_q;

    if (clr_done) begin
      done_d    = 1'b0;
      err_d     = 1'b0;
      aborted_d = 1'b0;
    end

    if ((state_q != IDLE) && wb_ack) begin
      wb_cnt_d = wb_cnt_q + CNT_W'(1);
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          done_d    = 1'b0;
          err_d     = 1'b0;
          aborted_d = 1'b0;
          if (cfg_ok) begin
            state_d  = ISSUE;
            wb_cnt_d = '0;
          end else begin
            err_d  = 1'b1;
            done_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
        end else if (op_hs && idx_final) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d   = IDLE;
          aborted_d = 1'b1;
          done_d    = 1'b0;
          err_d     = 1'b0;
        end else if (wb_cnt_q == mn_total) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Packed status word.
  always_comb begin
    status             = '0;
    status[STAT_BUSY]  = busy;
    status[STAT_DONE]  = done_q;
    status[STAT_ERR]   = err_q;
    status[STAT_ABORT] = aborted_q;
  end

endmodule
